sram_fun_ctrl: RTL and testbench
================================

SRAM_FUN_CTRL -- requirements
Module: sram_fun_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; there are no parameters.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  1  transfer request; held high with all request fields stable until ack.
REQ-005 we  in  1  1 = write, 0 = read.
REQ-006 size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
REQ-007 addr  in  13  byte address of the first byte.
REQ-008 wdata  in  32  write data, little-endian.
REQ-009 ack  out  1  one-cycle completion pulse.
REQ-010 err  out  1  one-cycle error pulse, coincident with ack.
REQ-011 rdata  out  32  read data, valid while ack=1; unused upper bytes are 0.
REQ-012 busy  out  1  high whenever the FSM is not IDLE.
REQ-013 bist_ten  in  1  BIST test enable, used for request lockout.
REQ-014 Addr_fun  out  13  SRAM functional address.
REQ-015 cen_fun / wen_fun / oen_fun  out  1 each  SRAM chip enable / write enable / output enable, all active-low.
REQ-016 wdata_fun  out  8  SRAM functional write byte.
REQ-017 Data  in  8  SRAM read byte, valid the cycle after a read beat.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, CAPTURE, DONE.
REQ-019 In IDLE with req=1 and not locked out, the block SHALL latch we, size, addr and wdata.
- It SHALL then clear the beat counter and enter ACCESS.
REQ-020 A misaligned request SHALL go to DONE with err=1 and SHALL make no SRAM access. Misaligned means:
- size=1 with addr[0]=1;
- size=2 with addr[1:0]!=0;
- size=3.
REQ-021 Beat count SHALL be 1, 2 or 4 for byte, halfword or word.
REQ-022 ACCESS SHALL issue one beat per cycle. Each beat drives:
- Addr_fun = addr+beat;
- cen_fun = 0;
- write: wen_fun = 0, oen_fun = 1, wdata_fun = wdata[8*beat+7:8*beat];
- read: wen_fun = 1, oen_fun = 0.
REQ-023 For a read, Data SHALL be captured into rdata[8k+7:8k] in the cycle after beat k is issued.
- The last byte is captured in CAPTURE.
REQ-024 After the last beat, a write SHALL go ACCESS->DONE and a read SHALL go ACCESS->CAPTURE->DONE.
REQ-025 DONE SHALL assert ack for one cycle, then return to IDLE.
- A req still high in that IDLE cycle is a new request.
REQ-026 Latency SHALL be measured from the IDLE cycle in which req is sampled (T):
- write of N beats: ack at T+N+1;
- read of N beats: ack at T+N+2;
- error: ack at T+1.
REQ-027 Because requests are aligned, address arithmetic SHALL never pass 8191; a word at 8188 SHALL use bytes 8188..8191.
REQ-028 Outside ACCESS, SRAM outputs SHALL be idle: cen_fun = wen_fun = oen_fun = 1, Addr_fun = 0, wdata_fun = 0.
REQ-029 rdata SHALL be cleared when a request is accepted.
- rdata SHALL hold its value after ack until the next accept.

Reset
REQ-030 When reset=1 at a clock edge, the FSM SHALL go to IDLE and the beat counter and rdata SHALL clear.
REQ-031 While reset=1, outputs SHALL take their reset values: ack = 0, err = 0, busy = 0, SRAM outputs idle.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no ack, and no further beats SHALL be issued.

Configuration
REQ-033 With macro SRAMC_BIST_LOCKOUT_EN defined, a request SHALL NOT be accepted in IDLE while bist_ten=1.
- req stays pending until bist_ten=0.
- A transfer already in progress SHALL complete normally.
REQ-034 Without SRAMC_BIST_LOCKOUT_EN, bist_ten SHALL be ignored; the port remains present.

Verification
REQ-035 Word write: we=1, size=2, addr=0x0010, wdata=0xA1B2C3D4 ->
- beats at 0x10..0x13 with bytes D4, C3, B2, A1;
- ack at T+5.
REQ-036 Word read of the same location ->
- rdata = 0xA1B2C3D4, err = 0;
- ack at T+6, with 4 beats having oen_fun = 0.
REQ-037 Byte read at 0x1FFF where the SRAM holds 0x5A ->
- rdata = 0x0000005A;
- ack at T+3.
REQ-038 Halfword request with addr=0x0003 -> ack and err at T+1, cen_fun stays 1.
REQ-039 Reset asserted during beat 2 of a word write ->
- next cycle: IDLE, busy = 0, SRAM outputs idle;
- no ack.
REQ-040 With SRAMC_BIST_LOCKOUT_EN defined: bist_ten=1 with req=1 for 10 cycles ->
- no beats issued;
- after bist_ten falls, the request is accepted and a byte write completes with ack 2 cycles later.

Source files
------------

// File: rtl/sram_fun_ctrl_if.sv
// Purpose : request/response bus between a host and sram_fun_ctrl.
// Latency : none; this is wiring only.
// Backpressure: the host holds req with stable fields until ack.
// Ports (master = host side, slave = controller side):
//   req, we, size[1:0], addr[12:0], wdata[31:0]   host -> controller
//   ack, err, rdata[31:0], busy                    controller -> host
interface sram_fun_ctrl_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic [12:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic        err;
   logic [31:0] rdata;
   logic        busy;

   modport master (
      output req, we, size, addr, wdata,
      input  ack, err, rdata, busy
   );

   modport slave (
      input  req, we, size, addr, wdata,
      output ack, err, rdata, busy
   );
endinterface

// File: rtl/sram_fun_ctrl.sv
// Purpose : splits byte/halfword/word requests into byte beats on a single-port SRAM.
// Latency : ack at T+N+1 (write), T+N+2 (read), T+1 (misaligned), T = request sample cycle.
// Backpressure: one request at a time; req held until ack, busy high while not IDLE.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   host (slave)        req/we/size/addr/wdata in, ack/err/rdata/busy out
//   bist_ten            BIST test enable (request lockout)
//   Addr_fun, cen_fun, wen_fun, oen_fun, wdata_fun   SRAM functional outputs (controls active-low)
//   Data                SRAM read byte, valid the cycle after a read beat
// Option: define SRAMC_BIST_LOCKOUT_EN to block new requests while bist_ten=1.
module sram_fun_ctrl (
   input  logic              clk,
   input  logic              reset,
   sram_fun_ctrl_if.slave    host,
   input  logic              bist_ten,
   output logic [12:0]       Addr_fun,
   output logic              cen_fun,
   output logic              wen_fun,
   output logic              oen_fun,
   output logic [7:0]        wdata_fun,
   input  logic [7:0]        Data
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

   state_t      state;
   logic        we_q;
   logic [1:0]  size_q;
   logic [12:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  beat;
   logic [31:0] rdata_q;
   logic        ack_q;
   logic        err_q;
   logic        busy_q;

   logic        misaligned;
   logic [1:0]  last_beat;
   logic [1:0]  beat_nx;
   logic [1:0]  beat_pv;
   logic        lockout;

`ifdef SRAMC_BIST_LOCKOUT_EN
   assign lockout = bist_ten;
`else
   logic unused_bist;
   assign unused_bist = bist_ten;
   assign lockout     = 1'b0;
`endif

   // Alignment is judged on the live request fields, before latching.
   assign misaligned = (host.size == 2'd3) ||
                       ((host.size == 2'd1) && host.addr[0]) ||
                       ((host.size == 2'd2) && (host.addr[1:0] != 2'b00));

   // Index of the final beat: 0, 1 or 3.
   assign last_beat = (size_q == 2'd0) ? 2'd0 :
                      (size_q == 2'd1) ? 2'd1 : 2'd3;

   assign beat_nx = beat + 2'd1;
   // A read byte arrives one cycle after its beat, so it belongs to the previous beat.
   assign beat_pv = beat - 2'd1;

   assign host.ack   = ack_q;
   assign host.err   = err_q;
   assign host.rdata = rdata_q;
   assign host.busy  = busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= 13'd0;
         wdata_q   <= 32'd0;
         beat      <= 2'd0;
         rdata_q   <= 32'd0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         Addr_fun  <= 13'd0;
         cen_fun   <= 1'b1;
         wen_fun   <= 1'b1;
         oen_fun   <= 1'b1;
         wdata_fun <= 8'd0;
      end else begin
         // Pulses and SRAM pins fall back to idle unless a branch drives a beat.
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         Addr_fun  <= 13'd0;
         cen_fun   <= 1'b1;
         wen_fun   <= 1'b1;
         oen_fun   <= 1'b1;
         wdata_fun <= 8'd0;

         case (state)
            IDLE: begin
               if (host.req && !lockout) begin
                  we_q    <= host.we;
                  size_q  <= host.size;
                  addr_q  <= host.addr;
                  wdata_q <= host.wdata;
                  beat    <= 2'd0;
                  rdata_q <= 32'd0;
                  busy_q  <= 1'b1;
                  if (misaligned) begin
                     state <= DONE;
                     ack_q <= 1'b1;
                     err_q <= 1'b1;
                  end else begin
                     // Beat 0 comes straight from the request fields.
                     state    <= ACCESS;
                     Addr_fun <= host.addr;
                     cen_fun  <= 1'b0;
                     if (host.we) begin
                        wen_fun   <= 1'b0;
                        wdata_fun <= host.wdata[7:0];
                     end else begin
                        oen_fun <= 1'b0;
                     end
                  end
               end
            end

            ACCESS: begin
               if (!we_q && (beat != 2'd0))
                  rdata_q[{beat_pv, 3'b000} +: 8] <= Data;
               if (beat == last_beat) begin
                  if (we_q) begin
                     state <= DONE;
                     ack_q <= 1'b1;
                  end else begin
                     state <= CAPTURE;
                  end
               end else begin
                  beat     <= beat_nx;
                  Addr_fun <= addr_q + {11'd0, beat_nx};
                  cen_fun  <= 1'b0;
                  if (we_q) begin
                     wen_fun   <= 1'b0;
                     wdata_fun <= wdata_q[{beat_nx, 3'b000} +: 8];
                  end else begin
                     oen_fun <= 1'b0;
                  end
               end
            end

            CAPTURE: begin
               rdata_q[{beat, 3'b000} +: 8] <= Data;
               state <= DONE;
               ack_q <= 1'b1;
            end

            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end

            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_fun_ctrl.sv
// Purpose : randomized and directed checks of sram_fun_ctrl against a transaction-level model.
// Latency : n/a (bench).
// Backpressure: req held until ack, as a well-behaved host.
module tb_sram_fun_ctrl;

   logic        clk;
   logic        reset;
   logic        bist_ten;
   logic [12:0] Addr_fun;
   logic        cen_fun;
   logic        wen_fun;
   logic        oen_fun;
   logic [7:0]  wdata_fun;
   logic [7:0]  Data;

   sram_fun_ctrl_if bus ();

   sram_fun_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .host      (bus),
      .bist_ten  (bist_ten),
      .Addr_fun  (Addr_fun),
      .cen_fun   (cen_fun),
      .wen_fun   (wen_fun),
      .oen_fun   (oen_fun),
      .wdata_fun (wdata_fun),
      .Data      (Data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] sram_mem [8192];
   logic [7:0] ref_mem  [8192];

   function automatic logic [7:0] init_byte(input int i);
      return 8'(i * 37 + 11) ^ 8'(i >> 5);
   endfunction

   // Synchronous SRAM: read data appears the cycle after the beat.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8192; i++) sram_mem[i] <= init_byte(i);
         Data <= 8'd0;
      end else if (!cen_fun) begin
         if (!wen_fun) sram_mem[Addr_fun] <= wdata_fun;
         else          Data <= sram_mem[Addr_fun];
      end
   end

   task automatic init_ref();
      for (int i = 0; i < 8192; i++) ref_mem[i] = init_byte(i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // One full transfer from an IDLE cycle; checks latency, err, beats, rdata, idle pins.
   task automatic run_txn(input logic w, input logic [1:0] sz, input logic [12:0] a,
                          input logic [31:0] wd);
      int          n, exp_lat, lat, idle_bad;
      logic        err_exp, got, obs_err;
      logic [31:0] exp_rd, obs_rd;
      logic [26:0] beats[$];
      logic [26:0] exp_beat;

      @(posedge clk); #1;
      chk("busy_before", {31'd0, bus.busy}, 32'd0);
      bus.req = 1'b1; bus.we = w; bus.size = sz; bus.addr = a; bus.wdata = wd;

      n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      err_exp = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
      exp_lat = err_exp ? 1 : (w ? n + 1 : n + 2);
      exp_rd  = 32'd0;
      if (!err_exp && !w)
         for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = ref_mem[a + 13'(k)];

      got = 1'b0; lat = 0; idle_bad = 0; obs_err = 1'b0; obs_rd = 32'd0;
      for (int c = 1; c <= 12 && !got; c++) begin
         @(posedge clk); #1;
         // bist_ten changing mid-transfer must never disturb it.
         if (c == 1) bist_ten = 1'($urandom_range(0, 1));
         if (!cen_fun)
            beats.push_back({c[3:0], Addr_fun, wen_fun, oen_fun, (w ? wdata_fun : 8'd0)});
         else if (wen_fun !== 1'b1 || oen_fun !== 1'b1 || Addr_fun !== 13'd0 || wdata_fun !== 8'd0)
            idle_bad++;
         if (bus.ack === 1'b1) begin
            got = 1'b1; lat = c; obs_err = bus.err; obs_rd = bus.rdata;
         end
      end
      bus.req = 1'b0; bist_ten = 1'b0;

      chk("ack_seen", {31'd0, got}, 32'd1);
      chk("latency", lat, exp_lat);
      chk("err", {31'd0, obs_err}, {31'd0, err_exp});
      chk("idle_pins", idle_bad, 0);
      chk("beat_count", beats.size(), err_exp ? 0 : n);
      if (!err_exp) begin
         for (int k = 0; k < n && k < beats.size(); k++) begin
            exp_beat = {4'(k + 1), a + 13'(k), (w ? 1'b0 : 1'b1), (w ? 1'b1 : 1'b0),
                        (w ? wd[8*k +: 8] : 8'd0)};
            chk("beat", {5'd0, beats[k]}, {5'd0, exp_beat});
         end
         if (w) for (int k = 0; k < n; k++) ref_mem[a + 13'(k)] = wd[8*k +: 8];
         else   chk("rdata", obs_rd, exp_rd);
      end

      @(posedge clk); #1;
      chk("ack_pulse", {31'd0, bus.ack}, 32'd0);
      chk("busy_after", {31'd0, bus.busy}, 32'd0);
      if (!err_exp && !w) chk("rdata_hold", bus.rdata, exp_rd);
   endtask

   task automatic reset_mid_write();
      int late;
      @(posedge clk); #1;
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = 13'h0040; bus.wdata = 32'h11223344;
      for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; end
      chk("beat2_addr", {19'd0, Addr_fun}, 32'h42);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_ack", {31'd0, bus.ack}, 32'd0);
      chk("rst_pins", {19'd0, Addr_fun, cen_fun, wen_fun, oen_fun, wdata_fun[0]},
          {19'd0, 13'd0, 1'b1, 1'b1, 1'b1, 1'b0});
      bus.req = 1'b0; reset = 1'b0;
      init_ref();
      late = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (bus.ack === 1'b1 || cen_fun !== 1'b1) late++;
      end
      chk("no_ack_after_abort", late, 0);
      chk("rdata_cleared", bus.rdata, 32'd0);
   endtask

   task automatic bist_test();
      int beats, lat;
      @(posedge clk); #1;
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.addr = 13'h0100; bus.wdata = 32'h000000C7;
      bist_ten = 1'b1;
      lat = 0;
`ifdef SRAMC_BIST_LOCKOUT_EN
      beats = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (cen_fun !== 1'b1 || bus.busy !== 1'b0) beats++;
      end
      chk("bist_locked", beats, 0);
      bist_ten = 1'b0;
`endif
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(posedge clk); #1;
         if (bus.ack === 1'b1) lat = c;
      end
      bus.req = 1'b0; bist_ten = 1'b0;
      chk("bist_ack_lat", lat, 2);
      ref_mem[13'h0100] = 8'hC7;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [1:0]  sz;
      logic [12:0] a;
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.addr = 13'd0; bus.wdata = 32'd0;
      bist_ten = 1'b0;
      reset = 1'b1;
      init_ref();
      @(posedge clk); #1;
      chk("reset_outs", {26'd0, bus.ack, bus.err, bus.busy, cen_fun, wen_fun, oen_fun},
          {26'd0, 3'b000, 3'b111});
      chk("reset_rdata", bus.rdata, 32'd0);
      chk("reset_addr", {11'd0, Addr_fun, wdata_fun}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_txn(1'b1, 2'd2, 13'h0010, 32'hA1B2C3D4);
      run_txn(1'b0, 2'd2, 13'h0010, 32'h0);
      run_txn(1'b1, 2'd0, 13'h1FFF, 32'h0000005A);
      run_txn(1'b0, 2'd0, 13'h1FFF, 32'h0);
      run_txn(1'b1, 2'd1, 13'h0003, 32'hDEADBEEF);
      run_txn(1'b0, 2'd3, 13'h0000, 32'h0);
      run_txn(1'b1, 2'd2, 13'h1FFC, 32'h55AA33CC);
      run_txn(1'b0, 2'd2, 13'h1FFC, 32'h0);
      run_txn(1'b0, 2'd1, 13'h0102, 32'h0);

      reset_mid_write();
      bist_test();
      run_txn(1'b0, 2'd0, 13'h0100, 32'h0);

      for (int t = 0; t < 60; t++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 13'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         run_txn(1'($urandom_range(0, 1)), sz, a, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
